// File: rtl/sample_packer_fifo_pkg.sv
// Shared widths, packer state encoding and FIFO entry layout for the sample packer FIFO.
package sample_packer_fifo_pkg;

    localparam int unsigned HalfWidth = 16;
    localparam int unsigned WordWidth = 32;
    localparam int unsigned DropWidth = 16;

    localparam logic [DropWidth-1:0] DropSat = 16'hFFFF;

    localparam logic [0:0] PEmpty = 1'b0;
    localparam logic [0:0] PLow   = 1'b1;

    typedef struct packed {
        logic                 half;
        logic [WordWidth-1:0] data;
    } fifo_word_t;

    localparam int unsigned EntryWidth = $bits(fifo_word_t);

    function automatic logic [DropWidth-1:0] sat_inc(input logic [DropWidth-1:0] v);
        return (v == DropSat) ? v : v + DropWidth'(1);
    endfunction

endpackage

// File: rtl/sample_packer_fifo_if.sv
// Sampler-side input, host-side valid/ready output and status of the sample packer FIFO.
interface sample_packer_fifo_if #(
    parameter int unsigned aw = 9
);
    import sample_packer_fifo_pkg::*;

    logic [HalfWidth-1:0] in_data;
    logic                 in_strobe;
    logic                 flush;
    logic                 clear;
    logic [WordWidth-1:0] out_data;
    logic                 out_half;
    logic                 out_valid;
    logic                 out_ready;
    logic [aw:0]          level;
    logic                 overflow;
    logic [DropWidth-1:0] drop_count;

    modport master (
        output in_data, in_strobe, flush, clear, out_ready,
        input  out_data, out_half, out_valid, level, overflow, drop_count
    );

    modport slave (
        input  in_data, in_strobe, flush, clear, out_ready,
        output out_data, out_half, out_valid, level, overflow, drop_count
    );

endinterface

// File: rtl/sample_fifo_mem.sv
// Simple dual-port RAM with registered read, shaped for block-RAM inference.
module sample_fifo_mem #(
    parameter int unsigned AddrWidth = 9,
    parameter int unsigned DataWidth = 33
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [DataWidth-1:0] rd_data_o
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_packer_fifo.sv
// Packs sampler halfwords into 32-bit words, buffers them and counts words lost to overflow.
module sample_packer_fifo
    import sample_packer_fifo_pkg::*;
#(
    parameter int unsigned aw = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sample_packer_fifo_if.slave  bus
);

    localparam int unsigned Depth    = 1 << aw;
    localparam logic [aw:0] DepthLvl = (aw + 1)'(Depth);

    logic [0:0]           pstate_q, pstate_d;
    logic [HalfWidth-1:0] low_q, low_d;
    logic                 push_req;
    fifo_word_t           push_word;

    logic                 push_acc, drop, pop, rd_en;
    logic [aw-1:0]        wr_ptr_q, rd_ptr_q;
    logic [aw:0]          level_q, level_d, unread;
    logic                 out_valid_q, out_valid_d;
    logic                 overflow_q, overflow_d;
    logic [DropWidth-1:0] drop_q, drop_d;
    fifo_word_t           rd_word;

    always_comb begin
        pstate_d  = pstate_q;
        low_d     = low_q;
        push_req  = 1'b0;
        push_word = '0;
        if (bus.in_strobe) begin
            if (pstate_q == PLow) begin
                push_req       = 1'b1;
                push_word.data = {bus.in_data, low_q};
                pstate_d       = PEmpty;
            end else if (bus.flush) begin
                push_req       = 1'b1;
                push_word.half = 1'b1;
                push_word.data = {{HalfWidth{1'b0}}, bus.in_data};
            end else begin
                low_d    = bus.in_data;
                pstate_d = PLow;
            end
        end else if (bus.flush && pstate_q == PLow) begin
            push_req       = 1'b1;
            push_word.half = 1'b1;
            push_word.data = {{HalfWidth{1'b0}}, low_q};
            pstate_d       = PEmpty;
        end
    end

    // Room is judged on the start-of-cycle level; a same-cycle pop does not help.
    assign push_acc = push_req && (level_q < DepthLvl) && !bus.clear;
    assign drop     = push_req && (level_q >= DepthLvl) && !bus.clear;
    assign pop      = out_valid_q && bus.out_ready && !bus.clear;

    // Words still in RAM: the output stage holds one already-read entry when valid.
    assign unread = level_q - {{aw{1'b0}}, out_valid_q};
    assign rd_en  = (unread != '0) && (!out_valid_q || pop) && !bus.clear;

    always_comb begin
        level_d = level_q;
        if (push_acc && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push_acc && pop) begin
            level_d = level_q - 1'b1;
        end

        out_valid_d = out_valid_q;
        if (rd_en) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        overflow_d = overflow_q | drop;
        drop_d     = drop ? sat_inc(drop_q) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            pstate_q    <= PEmpty;
            low_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            pstate_q    <= pstate_d;
            low_q       <= low_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    sample_fifo_mem #(
        .AddrWidth (aw),
        .DataWidth (EntryWidth)
    ) u_mem (
        .clk_i     (clk),
        .wr_en_i   (push_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (push_word),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_word)
    );

    // RAM read register is the output stage; masked so idle outputs read as zero.
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_valid_q ? rd_word.data : '0;
    assign bus.out_half   = out_valid_q & rd_word.half;
    assign bus.level      = level_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;

endmodule
